// File: rtl/usbh_crc_pkg.sv
// Shared constants for the USB host CRC engine: reflected polynomials,
// init values, good residuals, mode encodings and FSM states.
package usbh_crc_pkg;

  localparam logic MODE_CRC5  = 1'b0;
  localparam logic MODE_CRC16 = 1'b1;

  localparam logic [15:0] CRC5_POLY      = 16'h0014;
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC5_INIT      = 16'h001F;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC5_RESIDUAL  = 16'h0006;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } crc_state_t;

  // The init value is all ones over the active width, so it doubles as the output mask.
  function automatic logic [15:0] crc_init(input logic mode);
    return (mode == MODE_CRC16) ? CRC16_INIT : CRC5_INIT;
  endfunction

  function automatic logic [15:0] crc_residual(input logic mode);
    return (mode == MODE_CRC16) ? CRC16_RESIDUAL : CRC5_RESIDUAL;
  endfunction

endpackage

// File: rtl/usbh_crc_step.sv
// One-bit reflected (LSB-first) CRC update for either the CRC5 or the CRC16 register.
module usbh_crc_step
  import usbh_crc_pkg::*;
(
  input  logic        mode,
  input  logic [15:0] crc_in,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic fb;

  always_comb begin
    fb = crc_in[0] ^ bit_in;
    if (mode == MODE_CRC16) begin
      crc_out = (crc_in >> 1) ^ (fb ? CRC16_POLY : 16'h0000);
    end else begin
      // CRC5 keeps bits [15:5] at zero so the full word can be compared directly.
      crc_out = ({11'd0, crc_in[4:0]} >> 1) ^ (fb ? CRC5_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/usbh_crc_engine.sv
// USB token/data CRC generator and checker; processes a whole beat per cycle
// (SERIAL=0) or one bit per cycle through a single step instance (SERIAL=1).
module usbh_crc_engine
  import usbh_crc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SERIAL = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           mode_i,
  input  logic [DATA_W-1:0]              data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic                           last_i,
  input  logic [$clog2(DATA_W+1)-1:0]    last_bits_i,
  input  logic                           abort_i,
  output logic [15:0]                    crc_o,
  output logic                           match_o,
  output logic                           done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  crc_state_t  state_reg;
  logic        mode_reg;
  logic        run_en_reg;
  logic        match_reg;
  logic [15:0] crc_reg;
  logic [15:0] crc_out_reg;

  logic             accept;
  logic             busy;
  logic             stepping;
  logic             msg_end;
  logic             step_mode;
  logic [15:0]      crc_start;
  logic [15:0]      crc_next;
  logic [CNT_W-1:0] nbits;

  assign ready_o   = run_en_reg && (state_reg != ST_DONE) && !busy;
  assign accept    = valid_i && ready_o && !abort_i;
  // A first beat starts from the init value of the mode it carries.
  assign step_mode = (state_reg == ST_IDLE) ? mode_i : mode_reg;
  assign crc_start = (state_reg == ST_IDLE) ? crc_init(mode_i) : crc_reg;
  assign nbits     = (last_i && (last_bits_i != '0)) ? last_bits_i : CNT_W'(DATA_W);

  genvar gi;
  generate
    if (SERIAL != 0) begin : g_serial
      logic [CNT_W-1:0]  bit_cnt_reg;
      logic [CNT_W-1:0]  nbits_reg;
      logic [DATA_W-1:0] shift_reg;
      logic              last_reg;
      logic [CNT_W-1:0]  cur_idx;
      logic [CNT_W-1:0]  cur_nbits;
      logic              cur_last;
      logic              bit_in;
      logic              beat_end;

      // Bit 0 is consumed in the accept cycle; the rest come from the shift register.
      assign busy      = (bit_cnt_reg != '0);
      assign stepping  = busy || accept;
      assign cur_idx   = busy ? bit_cnt_reg : '0;
      assign cur_nbits = busy ? nbits_reg : nbits;
      assign cur_last  = busy ? last_reg : last_i;
      assign bit_in    = busy ? shift_reg[0] : data_i[0];
      assign beat_end  = stepping && (cur_idx == (cur_nbits - CNT_W'(1)));
      assign msg_end   = beat_end && cur_last;

      usbh_crc_step u_step (
        .mode    (step_mode),
        .crc_in  (crc_start),
        .bit_in  (bit_in),
        .crc_out (crc_next)
      );

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          bit_cnt_reg <= '0;
          nbits_reg   <= '0;
          shift_reg   <= '0;
          last_reg    <= 1'b0;
        end else if (abort_i) begin
          bit_cnt_reg <= '0;
        end else if (stepping) begin
          bit_cnt_reg <= beat_end ? '0 : cur_idx + CNT_W'(1);
          if (accept) begin
            shift_reg <= data_i >> 1;
            nbits_reg <= nbits;
            last_reg  <= last_i;
          end else begin
            shift_reg <= shift_reg >> 1;
          end
        end
      end
    end else begin : g_parallel
      logic [DATA_W:0][15:0] chain;

      assign chain[0] = crc_start;
      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
        logic [15:0] step_out;

        usbh_crc_step u_step (
          .mode    (step_mode),
          .crc_in  (chain[gi]),
          .bit_in  (data_i[gi]),
          .crc_out (step_out)
        );

        // Bits above the valid count of a final beat pass the register through.
        assign chain[gi+1] = (CNT_W'(gi) < nbits) ? step_out : chain[gi];
      end

      assign crc_next = chain[DATA_W];
      assign busy     = 1'b0;
      assign stepping = accept;
      assign msg_end  = accept && last_i;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= MODE_CRC5;
      run_en_reg  <= 1'b0;
      crc_reg     <= CRC16_INIT;
      crc_out_reg <= 16'h0000;
      match_reg   <= 1'b0;
    end else begin
      run_en_reg <= 1'b1;
      if (abort_i) begin
        state_reg <= ST_IDLE;
      end else begin
        if (accept && (state_reg == ST_IDLE)) begin
          mode_reg <= mode_i;
        end
        if (stepping) begin
          crc_reg <= crc_next;
        end
        case (state_reg)
          ST_DONE: state_reg <= ST_IDLE;
          default: begin
            if (msg_end) begin
              state_reg   <= ST_DONE;
              crc_out_reg <= ~crc_next & crc_init(step_mode);
              match_reg   <= (crc_next == crc_residual(step_mode));
            end else if (accept) begin
              state_reg <= ST_RUN;
            end
          end
        endcase
      end
    end
  end

  assign crc_o   = crc_out_reg;
  assign match_o = match_reg;
  assign done_o  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_usbh_crc_engine.sv
// Bench for usbh_crc_engine: one parallel and one serial instance driven with
// known vectors and random messages, checked against an MSB-first CRC model.
module tb_usbh_crc_engine;

  logic        clk;
  logic        rst_n     [2];
  logic        mode      [2];
  logic [7:0]  data      [2];
  logic        valid     [2];
  logic        ready     [2];
  logic        last      [2];
  logic [3:0]  last_bits [2];
  logic        abort     [2];
  logic [15:0] crc       [2];
  logic        match     [2];
  logic        done      [2];

  logic [7:0] msg [0:15];
  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  usbh_crc_engine #(.DATA_W(8), .SERIAL(0)) dut_par (
    .clk_i(clk), .rst_i(rst_n[0]), .mode_i(mode[0]), .data_i(data[0]),
    .valid_i(valid[0]), .ready_o(ready[0]), .last_i(last[0]),
    .last_bits_i(last_bits[0]), .abort_i(abort[0]), .crc_o(crc[0]),
    .match_o(match[0]), .done_o(done[0])
  );

  usbh_crc_engine #(.DATA_W(8), .SERIAL(1)) dut_ser (
    .clk_i(clk), .rst_i(rst_n[1]), .mode_i(mode[1]), .data_i(data[1]),
    .valid_i(valid[1]), .ready_o(ready[1]), .last_i(last[1]),
    .last_bits_i(last_bits[1]), .abort_i(abort[1]), .crc_o(crc[1]),
    .match_o(match[1]), .done_o(done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Textbook MSB-first CRC over the transmitted bit order; the result is
  // bit-reversed into crc_o's LSB-first transmit order.
  function automatic logic [16:0] crc_model(input logic md, input int nb, input int lastbits);
    int w;
    int nbits;
    logic [15:0] poly, mask, r, inv, res;
    logic [7:0] byte_sh;
    logic fb;
    w    = md ? 16 : 5;
    poly = md ? 16'h8005 : 16'h0005;
    mask = md ? 16'hFFFF : 16'h001F;
    r    = mask;
    for (int i = 0; i < nb; i++) begin
      nbits = (i == nb - 1 && lastbits != 0) ? lastbits : 8;
      for (int j = 0; j < nbits; j++) begin
        byte_sh = msg[i] >> j;
        fb = ((r >> (w - 1)) & 16'h1) != 16'h0;
        fb = fb ^ byte_sh[0];
        r = ((r << 1) & mask) ^ (fb ? poly : 16'h0000);
      end
    end
    inv = ~r & mask;
    res = 16'h0000;
    for (int k = 0; k < w; k++) begin
      res = res | (((inv >> (w - 1 - k)) & 16'h1) << k);
    end
    return {(r == (md ? 16'h800D : 16'h000C)), res};
  endfunction

  task automatic load_digits();
    for (int i = 0; i < 9; i++) msg[i] = 8'(8'h31 + i);
  endtask

  // Offers nb beats back to back; kill_kind 1 = abort, 2 = reset at beat kill_at.
  task automatic run_msg(input int s, input logic md, input int nb, input int lastbits,
                         input int kill_at, input int kill_kind,
                         output logic got_done, output logic [15:0] crc_got, output logic match_got,
                         output logic [15:0] crc_h, output logic match_h,
                         output int cyc, output int lows);
    int i;
    int guard;
    int early;
    logic rdy;
    logic started;
    i = 0; guard = 0; early = 0; started = 1'b0;
    got_done = 1'b0; crc_got = '0; match_got = 1'b0; crc_h = '0; match_h = 1'b0;
    cyc = 0; lows = 0;
    while (i < nb && guard < 4000) begin
      mode[s]      = md;
      data[s]      = msg[i];
      last[s]      = (i == nb - 1);
      last_bits[s] = (i == nb - 1) ? 4'(lastbits) : 4'd0;
      valid[s]     = 1'b1;
      if (i == kill_at) begin
        if (kill_kind == 1) abort[s] = 1'b1;
        else rst_n[s] = 1'b0;
        @(posedge clk); #1;
        abort[s] = 1'b0; valid[s] = 1'b0; last[s] = 1'b0;
        if (kill_kind == 2) begin
          check("kill_rst_ready", ready[s], 1'b0);
          check("kill_rst_crc", crc[s], 16'h0000);
          @(posedge clk); #1;
          rst_n[s] = 1'b1;
          @(posedge clk); #1;
          check("kill_rst_ready_back", ready[s], 1'b1);
        end
        for (int k = 0; k < 40; k++) begin
          if (done[s]) got_done = 1'b1;
          @(posedge clk); #1;
        end
        check("kill_ready", ready[s], 1'b1);
        return;
      end
      rdy = ready[s];
      @(posedge clk); #1;
      guard++;
      if (started) cyc++;
      if (rdy) begin
        started = 1'b1;
        i++;
      end
      if (done[s] && i < nb) early++;
      if (started && !done[s] && !ready[s]) lows++;
    end
    valid[s] = 1'b0;
    last[s]  = 1'b0;
    while (!done[s] && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      cyc++;
      if (!done[s] && !ready[s]) lows++;
    end
    check("no_early_done", early, 0);
    check("done_seen", done[s], 1'b1);
    check("ready_in_done", ready[s], 1'b0);
    got_done  = done[s];
    crc_got   = crc[s];
    match_got = match[s];
    @(posedge clk); #1;
    check("done_pulse", done[s], 1'b0);
    check("ready_after_done", ready[s], 1'b1);
    crc_h   = crc[s];
    match_h = match[s];
  endtask

  task automatic test_msg(input int s, input logic md, input int nb, input int lastbits,
                          input string tag, output logic [15:0] crc_got, output logic match_got);
    logic [16:0] exp;
    logic got_done, match_h;
    logic [15:0] crc_h;
    int cyc, lows, bits;
    exp  = crc_model(md, nb, lastbits);
    bits = 0;
    for (int i = 0; i < nb; i++) bits += (i == nb - 1 && lastbits != 0) ? lastbits : 8;
    run_msg(s, md, nb, lastbits, -1, 0, got_done, crc_got, match_got, crc_h, match_h, cyc, lows);
    check({tag, "_crc"}, crc_got, exp[15:0]);
    check({tag, "_match"}, match_got, exp[16]);
    check({tag, "_crc_hold"}, crc_h, exp[15:0]);
    check({tag, "_match_hold"}, match_h, exp[16]);
    check({tag, "_latency"}, cyc, (s == 1) ? bits - 1 : nb - 1);
    check({tag, "_ready_low"}, lows, (s == 1) ? bits - nb : 0);
    $display("msg %s dut=%0d mode=%0d beats=%0d lastbits=%0d crc=%04h match=%0b cycles=%0d",
             tag, s, md, nb, lastbits, crc_got, match_got, cyc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    logic m, gd, mh;
    logic [15:0] ch;
    logic [16:0] cm;
    int cy, lw, nb, nb0, lb;
    logic md;
    checks = 0;
    errors = 0;
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b1; mode[s] = 1'b0; data[s] = 8'h00; valid[s] = 1'b0;
      last[s] = 1'b0; last_bits[s] = 4'd0; abort[s] = 1'b0;
    end
    #3;
    for (int s = 0; s < 2; s++) rst_n[s] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_ready", ready[s], 1'b0);
      check("reset_done", done[s], 1'b0);
      check("reset_crc", crc[s], 16'h0000);
      check("reset_match", match[s], 1'b0);
      rst_n[s] = 1'b1;
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) check("ready_after_reset", ready[s], 1'b1);

    for (int s = 0; s < 2; s++) begin
      load_digits();
      test_msg(s, 1'b1, 9, 0, "c16", c, m);
      check("c16_vec", c, 16'hB4C8);
      test_msg(s, 1'b0, 9, 0, "c5", c, m);
      check("c5_vec", c, 16'h0019);

      msg[9] = 8'hC8; msg[10] = 8'hB4;
      test_msg(s, 1'b1, 11, 0, "resid", c, m);
      check("resid_match_vec", m, 1'b1);
      msg[10] = 8'hB5;
      test_msg(s, 1'b1, 11, 0, "bad", c, m);
      check("bad_match_vec", m, 1'b0);

      msg[0] = 8'h15; msg[1] = 8'h07;
      test_msg(s, 1'b0, 2, 3, "token", c, m);

      load_digits();
      run_msg(s, 1'b1, 9, 0, 3, 1, gd, c, m, ch, mh, cy, lw);
      check("abort_no_done", gd, 1'b0);
      test_msg(s, 1'b1, 9, 0, "post_abort", c, m);
      check("post_abort_vec", c, 16'hB4C8);

      run_msg(s, 1'b1, 9, 0, 5, 2, gd, c, m, ch, mh, cy, lw);
      check("reset_no_done", gd, 1'b0);
      test_msg(s, 1'b1, 9, 0, "post_reset", c, m);
      check("post_reset_vec", c, 16'hB4C8);

      for (int r = 0; r < 16; r++) begin
        md = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 0) begin
          nb = $urandom_range(1, 6);
          lb = $urandom_range(0, 7);
          for (int i = 0; i < nb; i++) msg[i] = 8'($urandom);
          test_msg(s, md, nb, lb, "rand", c, m);
        end else begin
          nb0 = $urandom_range(1, 5);
          for (int i = 0; i < nb0; i++) msg[i] = 8'($urandom);
          cm = crc_model(md, nb0, 0);
          if (md) begin
            msg[nb0]     = cm[7:0];
            msg[nb0 + 1] = cm[15:8];
            nb = nb0 + 2;
            lb = 0;
          end else begin
            msg[nb0] = {3'($urandom_range(0, 7)), cm[4:0]};
            nb = nb0 + 1;
            lb = 5;
          end
          test_msg(s, md, nb, lb, "rand_app", c, m);
          check("rand_app_match", m, 1'b1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
